// File: rtl/sobel_pkg.sv
// Shared constants for the 3x3 Sobel streaming filter.
// Output modes, FSM encoding and result-width helper.
package sobel_pkg;

  localparam logic [1:0] MODE_GX  = 2'b00;
  localparam logic [1:0] MODE_GY  = 2'b01;
  localparam logic [1:0] MODE_MAG = 2'b10;
  localparam logic [1:0] MODE_THR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FILL  = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;

  // Holds signed +/-4*max and unsigned 8*max
  function automatic int sobel_out_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_if.sv
// Valid/ready stream bundle used on both sides of the filter.
// master drives valid/data/last, slave drives ready.
interface sobel_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (
    output valid, data, last,
    input  ready
  );

  modport slave (
    input  valid, data, last,
    output ready
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer for 3x3 windows: lb0 is the previous row,
// lb1 the row before; one column address shared by read and write.
module sobel_line_buffer #(
  parameter  int IMG_W = 5,
  parameter  int PIX_W = 8,
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
)(
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_din,
  output logic [PIX_W-1:0] o_top,
  output logic [PIX_W-1:0] o_mid
);

  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];

  assign o_top = r_lb1[i_addr];
  assign o_mid = r_lb0[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_lb1[i_addr] <= r_lb0[i_addr];
      r_lb0[i_addr] <= i_din;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter: raster pixels in, one result per
// interior pixel out (Gx, Gy, |Gx|+|Gy| or thresholded edge bit).
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int PIX_W = 8,
  parameter int OUT_W = sobel_out_w(PIX_W)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_mode,
  input  logic [OUT_W-1:0] i_thresh,
  sobel_if.slave           s,
  sobel_if.master          m,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                          w_acc;
  logic                          w_mhs;
  logic                          w_win;
  logic                          w_eol;
  logic                          w_lastpix;
  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic [1:0]                    r_state;
  logic [1:0]                    r_mode;
  logic [OUT_W-1:0]              r_thr;
  logic [PIX_W-1:0]              w_top;
  logic [PIX_W-1:0]              w_mid;
  logic [2:0][2:0][PIX_W-1:0]    r_w;
  logic [2:0][2:0][PIX_W-1:0]    w_n;
  logic signed [OUT_W-1:0]       w_e [3][3];
  logic signed [OUT_W-1:0]       w_gx;
  logic signed [OUT_W-1:0]       w_gy;
  logic [OUT_W-1:0]              w_ax;
  logic [OUT_W-1:0]              w_ay;
  logic [OUT_W-1:0]              w_mag;
  logic [OUT_W-1:0]              w_res;
  logic                          r_mvalid;
  logic [OUT_W-1:0]              r_mdata;
  logic                          r_mlast;

  // Single output register: accept whenever it is free or draining
  assign s.ready   = !rst && (!r_mvalid || m.ready);
  assign w_acc     = s.valid && s.ready;
  assign w_mhs     = r_mvalid && m.ready;
  assign w_eol     = r_col == CW'(IMG_W - 1);
  assign w_win     = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_lastpix = w_eol && (r_row == RW'(IMG_H - 1));

  assign m.valid      = r_mvalid;
  assign m.data       = r_mdata;
  assign m.last       = r_mlast;
  assign o_busy       = r_state != ST_IDLE;
  assign o_frame_done = w_mhs && r_mlast;

  sobel_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_lb (
    .clk    (clk),
    .i_we   (w_acc),
    .i_addr (r_col),
    .i_din  (s.data),
    .o_top  (w_top),
    .o_mid  (w_mid)
  );

  always_comb begin
    w_n = r_w;
    for (int r = 0; r < 3; r++) begin
      w_n[r][0] = r_w[r][1];
      w_n[r][1] = r_w[r][2];
    end
    w_n[0][2] = w_top;
    w_n[1][2] = w_mid;
    w_n[2][2] = s.data;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_e[r][c] = OUT_W'(w_n[r][c]);
      end
    end
  end

  assign w_gx = (w_e[0][2] + (w_e[1][2] <<< 1) + w_e[2][2])
              - (w_e[0][0] + (w_e[1][0] <<< 1) + w_e[2][0]);
  assign w_gy = (w_e[2][0] + (w_e[2][1] <<< 1) + w_e[2][2])
              - (w_e[0][0] + (w_e[0][1] <<< 1) + w_e[0][2]);
  assign w_ax  = w_gx[OUT_W-1] ? -w_gx : w_gx;
  assign w_ay  = w_gy[OUT_W-1] ? -w_gy : w_gy;
  assign w_mag = w_ax + w_ay;

  always_comb begin
    w_res = '0;
    unique case (r_mode)
      MODE_GX:  w_res = w_gx;
      MODE_GY:  w_res = w_gy;
      MODE_MAG: w_res = w_mag;
      MODE_THR: w_res = OUT_W'(w_mag >= r_thr);
      default:  w_res = '0;
    endcase
  end

  // Window contents need no reset: they are refilled before use
  always_ff @(posedge clk) begin
    if (w_acc) r_w <= w_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_state  <= ST_IDLE;
      r_mode   <= MODE_GX;
      r_thr    <= '0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mlast  <= 1'b0;
    end else begin
      if (w_acc) begin
        if (r_col == '0 && r_row == '0) begin
          r_mode <= i_mode;
          r_thr  <= i_thresh;
        end
        if (w_eol) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_acc && w_win) begin
        r_mvalid <= 1'b1;
        r_mdata  <= w_res;
        r_mlast  <= w_lastpix;
      end else if (m.ready) begin
        r_mvalid <= 1'b0;
      end

      unique case (r_state)
        ST_IDLE:  if (w_acc) r_state <= ST_FILL;
        ST_FILL:  if (w_acc && w_eol && r_row == RW'(1))
                    r_state <= ST_RUN;
        ST_RUN:   if (w_acc && w_lastpix) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_mhs) r_state <= w_acc ? ST_FILL : ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream: a reference model queues the
// expected results per frame, a monitor pops them on each handshake.
module tb_sobel_stream;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 8;
  localparam int OW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [OW-1:0] thresh;
  logic          busy;
  logic          frame_done;

  sobel_if #(.W(PW)) s_if ();
  sobel_if #(.W(OW)) m_if ();

  sobel_stream #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mode       (mode),
    .i_thresh     (thresh),
    .s            (s_if),
    .m            (m_if),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  int            n_out = 0;
  int            n_last = 0;
  int            n_done = 0;
  int            stall_pct = 0;
  int            img [H][W];
  logic [OW:0]   q [$];
  logic          stab_v = 1'b0;
  logic [OW-1:0] stab_d;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input int r, input int c,
                                          input logic [1:0] md,
                                          input logic [OW-1:0] th);
    int gx, gy, mag;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    case (md)
      2'b00:   return OW'(gx);
      2'b01:   return OW'(gy);
      2'b10:   return OW'(mag);
      default: return (mag >= int'(th)) ? OW'(1) : OW'(0);
    endcase
  endfunction

  task automatic set_img(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 100;
          1: img[r][c] = 10 * c;
          2: img[r][c] = (c <= 2) ? 255 : 0;
          3: img[r][c] = 10 * r;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic drive_pix(input int v, input int gap_pct);
    logic acc;
    int   k;
    while (int'($urandom_range(0, 99)) < gap_pct) begin
      s_if.valid = 1'b0;
      @(posedge clk); #1;
    end
    s_if.valid = 1'b1;
    s_if.data  = PW'(v);
    k = 0;
    do begin
      @(negedge clk);
      acc = s_if.ready;
      @(posedge clk); #1;
      k++;
    end while (!acc && k < 200);
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic send_frame(input logic [1:0] md, input int th,
                            input int gap_pct, input int sw_at,
                            input logic [1:0] sw_md);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        q.push_back({(r == H-1 && c == W-1), model(r, c, md, OW'(th))});
    mode   = md;
    thresh = OW'(th);
    for (int i = 0; i < W*H; i++) begin
      if (i == sw_at) mode = sw_md;
      drive_pix(img[i / W][i % W], gap_pct);
    end
  endtask

  task automatic drain(input int exp_out, input int exp_frames);
    int k = 0;
    s_if.valid = 1'b0;
    while (q.size() != 0 && k < 2000) begin
      @(posedge clk); k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("out_count", n_out, exp_out);
    chk("last_count", n_last, exp_frames);
    chk("done_count", n_done, exp_frames);
    chk("busy_idle", busy, 0);
    n_out = 0; n_last = 0; n_done = 0;
  endtask

  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.ready = int'($urandom_range(0, 99)) >= stall_pct;
    end
  end

  initial begin
    logic [OW:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stab_v = 1'b0;
      end else begin
        if (stab_v) begin
          chk("stall_valid", m_if.valid, 1);
          chk("stall_data", m_if.data, stab_d);
        end
        stab_v = m_if.valid && !m_if.ready;
        stab_d = m_if.data;
        chk("s_ready", s_if.ready, !m_if.valid || m_if.ready);
        if (m_if.valid && m_if.ready) begin
          chk("q_nonempty", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("m_data", m_if.data, e[OW-1:0]);
            chk("m_last", m_if.last, e[OW]);
          end
          n_out++;
          if (m_if.last) n_last++;
        end
        if (frame_done) n_done++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    mode       = 2'b00;
    thresh     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_if.ready, 0);
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_m_data", m_if.data, 0);
    chk("rst_m_last", m_if.last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_if.ready, 1);

    set_img(0);
    send_frame(2'b00, 0, 0, -1, 2'b00);
    drain(9, 1);

    set_img(1);
    for (int md = 0; md < 3; md++) begin
      send_frame(2'(md), 0, 30, -1, 2'b00);
      drain(9, 1);
    end

    set_img(2);
    send_frame(2'b00, 0, 0, -1, 2'b00);
    drain(9, 1);
    send_frame(2'b11, 500, 0, -1, 2'b00);
    drain(9, 1);

    set_img(3);
    stall_pct = 50;
    send_frame(2'b01, 0, 20, -1, 2'b00);
    drain(9, 1);
    stall_pct = 0;
    @(posedge clk); #1;

    set_img(5);
    send_frame(2'b00, 0, 0, 7, 2'b01);
    send_frame(2'b01, 0, 0, -1, 2'b01);
    drain(18, 2);

    stall_pct = 100;
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) drive_pix(img[i / W][i % W], 0);
    s_if.valid = 1'b0;
    chk("pend_valid", m_if.valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_if.valid, 0);
    chk("mid_rst_s_ready", s_if.ready, 0);
    chk("mid_rst_busy", busy, 0);
    stall_pct = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_out = 0; n_last = 0; n_done = 0;
    set_img(0);
    send_frame(2'b00, 0, 0, -1, 2'b00);
    drain(9, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
